// File: rtl/phase_inc_pipeline_pkg.sv
// ----------------------------------------------------------------------------
// phase_inc_pipeline_pkg
//   Shared constants, types and helpers for the phase-increment pipeline.
//   Default widths, the vibrato divider, the phase_inc type, and the
//   frequency-multiple lookup.
// ----------------------------------------------------------------------------
package phase_inc_pipeline_pkg;

    localparam int NUM_OPS_DEF = 36;
    localparam int OP_W_DEF    = $clog2(NUM_OPS_DEF);
    localparam int FNUM_W_DEF  = 10;
    localparam int BLOCK_W_DEF = 3;
    localparam int PHASE_W_DEF = 22;
    localparam int VIB_DIV_DEF = 10;

    localparam int MULT_W   = 4;
    localparam int FACTOR_W = 5;

    typedef logic [PHASE_W_DEF-1:0] phase_inc_t;

    // Frequency multiple scaled by two, so the half multiple (code 0) stays
    // an integer. The final stage multiplies by this and drops one LSB.
    function automatic logic [FACTOR_W-1:0] mult_factor(input logic [MULT_W-1:0] code);
        logic [FACTOR_W-1:0] f2;
        case (code)
            4'h0:        f2 = 5'd1;
            4'hA, 4'hB:  f2 = 5'd20;
            4'hC, 4'hD:  f2 = 5'd24;
            4'hE, 4'hF:  f2 = 5'd30;
            default:     f2 = {code, 1'b0};
        endcase
        return f2;
    endfunction

endpackage

// File: rtl/phase_inc_pipeline_if.sv
// ----------------------------------------------------------------------------
// phase_inc_pipeline_if
//   Operator beat in, tagged phase increment out.
//   master : drives the beat (in_*, fnum, block, mult, vib, dvb),
//            receives out_valid / out_op / phase_inc.
//   slave  : the pipeline side.
// ----------------------------------------------------------------------------
interface phase_inc_pipeline_if #(
    parameter int OP_W    = phase_inc_pipeline_pkg::OP_W_DEF,
    parameter int FNUM_W  = phase_inc_pipeline_pkg::FNUM_W_DEF,
    parameter int BLOCK_W = phase_inc_pipeline_pkg::BLOCK_W_DEF,
    parameter int PHASE_W = phase_inc_pipeline_pkg::PHASE_W_DEF
) ();

    logic               in_valid;
    logic [OP_W-1:0]    in_op;
    logic [FNUM_W-1:0]  fnum;
    logic [BLOCK_W-1:0] block;
    logic [3:0]         mult;
    logic               vib;
    logic               dvb;

    logic               out_valid;
    logic [OP_W-1:0]    out_op;
    logic [PHASE_W-1:0] phase_inc;

    modport master (
        output in_valid, in_op, fnum, block, mult, vib, dvb,
        input  out_valid, out_op, phase_inc
    );

    modport slave (
        input  in_valid, in_op, fnum, block, mult, vib, dvb,
        output out_valid, out_op, phase_inc
    );

endinterface

// File: rtl/phase_inc_pipeline_vibrato_lfo.sv
// ----------------------------------------------------------------------------
// phase_inc_pipeline_vibrato_lfo
//   Free-running vibrato LFO and the signed F-number delta it implies.
//   Ports:
//     clk, reset_n   clock / async active-low reset
//     sample_clk_en  advances the LFO counter by one
//     fnum_msb       top three bits of the F-number
//     vib, dvb       vibrato enable, deep vibrato
//     delta          signed offset to add to the F-number (combinational,
//                    based on the counter value before this cycle's advance)
// ----------------------------------------------------------------------------
module phase_inc_pipeline_vibrato_lfo #(
    parameter int VIB_DIV = phase_inc_pipeline_pkg::VIB_DIV_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_clk_en,
    input  logic [2:0]        fnum_msb,
    input  logic              vib,
    input  logic              dvb,
    output logic signed [3:0] delta
);

    localparam int CNT_W = VIB_DIV + 3;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       pos;
    logic [2:0]       mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (sample_clk_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign pos = cnt[CNT_W-1 -: 3];

    // Triangle: 0, +1/2, +1, +1/2, 0, -1/2, -1, -1/2 of the F-number MSBs.
    always_comb begin
        mag = 3'd0;
        case (pos)
            3'd0, 3'd4: mag = 3'd0;
            3'd2, 3'd6: mag = fnum_msb;
            default:    mag = fnum_msb >> 1;
        endcase
        if (!dvb) begin
            mag = mag >> 1;
        end
        if (!vib) begin
            mag = 3'd0;
        end
    end

    // pos 4 has zero magnitude, so using pos[2] as the sign is safe.
    assign delta = pos[2] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});

endmodule

// File: rtl/phase_inc_pipeline.sv
// ----------------------------------------------------------------------------
// phase_inc_pipeline
//   Three-stage, time-multiplexed phase-increment generator. One operator
//   beat per clock, no stall; result appears three clocks later with its tag.
//     S1: F-number plus vibrato delta
//     S2: block (octave) shift
//     S3: frequency multiple
//   Ports:
//     clk            system clock
//     reset_n        async active-low reset; drops all in-flight beats
//     sample_clk_en  sample tick, advances the vibrato LFO
//     bus            slave side of phase_inc_pipeline_if (beat in, result out)
// ----------------------------------------------------------------------------
module phase_inc_pipeline
    import phase_inc_pipeline_pkg::*;
#(
    parameter int NUM_OPS = NUM_OPS_DEF,
    parameter int FNUM_W  = FNUM_W_DEF,
    parameter int BLOCK_W = BLOCK_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int VIB_DIV = VIB_DIV_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_clk_en,
    phase_inc_pipeline_if.slave bus
);

    localparam int OP_W = $clog2(NUM_OPS);

    // The widest shifted value times the largest multiple (x15) must fit.
    if (PHASE_W < FNUM_W + 1 + (2**BLOCK_W - 1) + 4) begin : g_phase_w_check
        $error("phase_inc_pipeline: PHASE_W too narrow for FNUM_W/BLOCK_W");
    end

    // ---------------- S1: vibrato ----------------
    logic signed [3:0]  vib_delta;
    logic [FNUM_W:0]    fnum_v_d;

    logic               s1_valid;
    logic [OP_W-1:0]    s1_op;
    logic [FNUM_W:0]    s1_fnum_v;
    logic [BLOCK_W-1:0] s1_block;
    logic [3:0]         s1_mult;

    phase_inc_pipeline_vibrato_lfo #(
        .VIB_DIV (VIB_DIV)
    ) u_lfo (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_clk_en (sample_clk_en),
        .fnum_msb      (bus.fnum[FNUM_W-1 -: 3]),
        .vib           (bus.vib),
        .dvb           (bus.dvb),
        .delta         (vib_delta)
    );

    // Sign-extended add; a negative delta only occurs with fnum >= 2^(FNUM_W-3),
    // so the unsigned result cannot wrap.
    assign fnum_v_d = {1'b0, bus.fnum} + {{(FNUM_W-3){vib_delta[3]}}, vib_delta};

    // ---------------- S2: block shift ----------------
    logic [PHASE_W-1:0] s1_ext;

    logic               s2_valid;
    logic [OP_W-1:0]    s2_op;
    logic [PHASE_W-1:0] s2_shifted;
    logic [3:0]         s2_mult;

    assign s1_ext = {{(PHASE_W-FNUM_W-1){1'b0}}, s1_fnum_v};

    // ---------------- S3: multiple ----------------
    logic [FACTOR_W-1:0] s2_factor;
    logic [PHASE_W:0]    s2_prod;

    logic               out_valid_q;
    logic [OP_W-1:0]    out_op_q;
    logic [PHASE_W-1:0] phase_inc_q;

    assign s2_factor = mult_factor(s2_mult);
    // Factor is x2-scaled; the extra product bit is dropped by the >>1.
    assign s2_prod   = {1'b0, s2_shifted} * {{(PHASE_W+1-FACTOR_W){1'b0}}, s2_factor};

    // ---------------- valid shift chain ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid    <= bus.in_valid;
            s2_valid    <= s1_valid;
            out_valid_q <= s2_valid;
        end
    end

    // ---------------- stage data (load only on valid) ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_op     <= '0;
            s1_fnum_v <= '0;
            s1_block  <= '0;
            s1_mult   <= '0;
        end else if (bus.in_valid) begin
            s1_op     <= bus.in_op;
            s1_fnum_v <= fnum_v_d;
            s1_block  <= bus.block;
            s1_mult   <= bus.mult;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_op      <= '0;
            s2_shifted <= '0;
            s2_mult    <= '0;
        end else if (s1_valid) begin
            s2_op      <= s1_op;
            s2_shifted <= s1_ext << s1_block;
            s2_mult    <= s1_mult;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_op_q    <= '0;
            phase_inc_q <= '0;
        end else if (s2_valid) begin
            out_op_q    <= s2_op;
            phase_inc_q <= PHASE_W'(s2_prod >> 1);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_op_q;
    assign bus.phase_inc = phase_inc_q;

endmodule
